// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the mux8 round-robin arbiter.
package mux8_arb_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWN
  } arb_state_e;

  // Binary requester index to one-hot grant vector.
  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Combinational circular priority search: first set bit of (req & ~mask),
// scanning upward from start with wrap-around.
module rr_pick
  import mux8_arb_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] start,
  input  logic [7:0] mask,
  output logic       found,
  output logic [2:0] idx
);

  logic [7:0] cand;
  logic [2:0] pos;

  // Scan the eight positions in circular order; the first candidate wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    cand  = req & ~mask;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = start + SEL_W'(i);
      if (!found && cand[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin grant controller driving the select of a shared mux8to1.
// Each grant lasts at most HOLD_MAX accepted beats (out_valid && out_ready),
// or until the owner drops its request; handover to a waiting requester
// happens at the releasing edge with no dead cycle.
// Optional build macro MUX8_ARB_FIXED_PRIO_EN: fixed priority (index 0
// highest), no fairness pointer; hold expiry still forces re-arbitration.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  arb_state_e state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] grant_q, grant_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;

  logic       owner_req;
  logic       accept;
  logic       hold_exp;
  logic       release_own;
  logic [2:0] pick_start;
  logic [7:0] pick_mask;
  logic       pick_found;
  logic [2:0] pick_idx;

`ifndef MUX8_ARB_FIXED_PRIO_EN
  logic [2:0] ptr_q, ptr_d;
`endif

  assign owner_req   = req[sel_q];
  assign busy        = (state_q == ARB_OWN);
  assign out_valid   = busy && owner_req;
  assign accept      = out_valid && out_ready;
  assign hold_exp    = accept && (beat_cnt_q == HOLD_LAST);
  assign release_own = busy && (!owner_req || hold_exp);
  assign grant       = grant_q;
  assign sel         = sel_q;

`ifdef MUX8_ARB_FIXED_PRIO_EN
  // Fixed priority: the expired owner stays eligible, so index 0 re-wins
  // immediately while it keeps requesting.
  assign pick_start = '0;
  assign pick_mask  = '0;
`else
  // From OWN the search begins just past the owner (the value ptr takes at
  // this edge); an expired owner is masked so it cannot re-win at handover.
  assign pick_start = busy ? (sel_q + 3'd1) : ptr_q;
  assign pick_mask  = hold_exp ? idx_to_onehot(sel_q) : '0;
`endif

  rr_pick u_pick (
    .req   (req),
    .start (pick_start),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state: acquire from IDLE, count beats, release and hand over.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
`ifndef MUX8_ARB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d    = ARB_OWN;
          sel_d      = pick_idx;
          grant_d    = idx_to_onehot(pick_idx);
          beat_cnt_d = '0;
        end
      end
      ARB_OWN: begin
        if (release_own) begin
`ifndef MUX8_ARB_FIXED_PRIO_EN
          ptr_d = sel_q + 3'd1;
`endif
          beat_cnt_d = '0;
          if (pick_found) begin
            sel_d   = pick_idx;
            grant_d = idx_to_onehot(pick_idx);
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      sel_q      <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
`ifndef MUX8_ARB_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
`ifndef MUX8_ARB_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter (default round-robin build,
// HOLD_MAX=4): per-cycle vector table plus an asynchronous-reset sequence.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int checks;
  int failures;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic [7:0] g;
    logic [2:0] s;
    logic       b;
    logic       v;
  } vec_t;

  vec_t vecs[$];

  mux8_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [7:0] r, input logic rdy,
                     input logic [7:0] g, input logic [2:0] s, input logic b, input logic v);
    vec_t e;
    e.rst = rst; e.req = r; e.rdy = rdy; e.g = g; e.s = s; e.b = b; e.v = v;
    vecs.push_back(e);
  endtask

  task automatic idle(input logic rst, input logic [7:0] r, input logic rdy);
    add(rst, r, rdy, 8'h00, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic own(input logic [7:0] r, input logic rdy, input logic [2:0] s);
    logic [7:0] oh;
    oh = 8'h01 << s;
    add(1'b0, r, rdy, oh, s, 1'b1, |(r & oh));
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n  = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req       = 8'h00;
    out_ready = 1'b0;

    // Reset state held with no requests.
    idle(1'b1, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) idle(1'b0, 8'h00, 1'b1);

    // Two requesters: 2 for 4 beats, 5 for 4 beats, back to 2, no gaps.
    idle(1'b1, 8'h24, 1'b1);
    for (int k = 0; k < 4; k++) own(8'h24, 1'b1, 3'd2);
    for (int k = 0; k < 4; k++) own(8'h24, 1'b1, 3'd5);
    own(8'h24, 1'b1, 3'd2);

    // All requesting: 0..7 then wrap to 0, four cycles each.
    idle(1'b1, 8'hFF, 1'b1);
    for (int k = 1; k <= 33; k++) own(8'hFF, 1'b1, 3'(((k - 1) / 4) % 8));

    // Owner 3 drops after 2 beats; search resumes from 4 so 6 beats 0.
    idle(1'b1, 8'h48, 1'b1);
    own(8'h48, 1'b1, 3'd3);
    own(8'h48, 1'b1, 3'd3);
    own(8'h41, 1'b1, 3'd3);
    for (int k = 0; k < 4; k++) own(8'h41, 1'b1, 3'd6);
    own(8'h41, 1'b1, 3'd0);

    // Consumer stalls 10 cycles after one beat; a late request waits.
    idle(1'b1, 8'h02, 1'b1);
    own(8'h02, 1'b1, 3'd1);
    for (int k = 0; k < 3; k++) own(8'h02, 1'b0, 3'd1);
    for (int k = 0; k < 7; k++) own(8'h12, 1'b0, 3'd1);
    for (int k = 0; k < 3; k++) own(8'h12, 1'b1, 3'd1);
    own(8'h12, 1'b1, 3'd4);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      req       = vecs[i].req;
      out_ready = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d.grant", i), 32'(grant), 32'(vecs[i].g));
      chk($sformatf("v%0d.sel", i), 32'(sel), 32'(vecs[i].s));
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].b));
      chk($sformatf("v%0d.valid", i), 32'(out_valid), 32'(vecs[i].v));
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-grant, after the pointer has advanced past 2.
    do_reset();
    req       = 8'h24;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst.sel", 32'(sel), 32'd5);
    chk("pre_rst.busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.grant", 32'(grant), 32'd0);
    chk("async_rst.sel", 32'(sel), 32'd0);
    chk("async_rst.busy", 32'(busy), 32'd0);
    chk("async_rst.valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst.sel", 32'(sel), 32'd2);
    chk("post_rst.grant", 32'(grant), 32'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
